imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for the core's word-indexed instruction memory. Receives a framed byte stream
//  (valid/ready) from a host link, assembles little-endian 32-bit words and writes them to
//  consecutive instruction-memory words starting at word 0. Holds the core in reset until a load
//  completes with a good checksum.
//  Frame: CNT_LO, CNT_HI (16-bit word count N), then 4*N payload bytes, then CSUM
//  (CSUM = XOR of all payload bytes).
// PARAMETERS
//  ADDR_WIDTH  6   width of mem_addr, in words
//  DEPTH       64  number of instruction-memory words; N must satisfy 1 <= N <= DEPTH
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           reset: asynchronous, active-high
//  start        in   1           1-cycle pulse; begins a new load
//  in_valid     in   1           byte present on in_data
//  in_data      in   8           stream byte
//  in_ready     out  1           loader accepts a byte; a byte transfers when in_valid & in_ready
//  mem_we       out  1           instruction-memory write strobe
//  mem_addr     out  ADDR_WIDTH  word address
//  mem_wdata    out  32          write word
//  core_reset   out  1           active-high reset to the core (PC, register file)
//  done         out  1           load finished, checksum good
//  error        out  1           load aborted
//  words_loaded out  16          words written in the current or last load
// BEHAVIOUR
//  Reset: state = IDLE; mem_addr = 0; mem_wdata = 0; words_loaded = 0; byte_idx = 0; csum = 0.
//   core_reset = 1; all other outputs = 0.
//  States:
//   - IDLE -> HDR0 on start.
//   - HDR0 -> HDR1 after a byte transfer; byte is cnt[7:0].
//   - HDR1: on a byte transfer, cnt[15:8] = byte. Go to ERROR if {byte,cnt[7:0]} == 0 or > DEPTH;
//     otherwise go to LOAD.
//   - LOAD: accepts 4*N bytes. Byte k of each word goes to word[8k+7:8k] (little-endian);
//     byte_idx wraps 3 -> 0. Each payload byte XORs into csum. Go to CSUM after the last byte
//     transfer.
//   - CSUM: on a byte transfer, go to DONE if byte == csum, else go to ERROR.
//   - DONE/ERROR: hold. start -> HDR0 from either state.
//  On entry to HDR0 (every start): clear csum, byte_idx, words_loaded, mem_addr; assert core_reset.
//  Outputs by state:
//   - in_ready = 1 in HDR0, HDR1, LOAD and CSUM; 0 in IDLE, DONE and ERROR.
//     The loader never stalls the stream inside a frame.
//   - core_reset = 1 in every state except DONE. It deasserts the cycle after DONE is entered.
//   - done = 1 only in DONE; error = 1 only in ERROR. Both are registered and mutually exclusive.
//  Write timing:
//   - mem_we is a 1-cycle pulse in the cycle after the 4th byte of a word transfers.
//     mem_wdata and mem_addr are registered and stable during that pulse.
//   - After the pulse: mem_addr increments, with wrap-around modulo 2^ADDR_WIDTH, which cannot
//     occur when N <= DEPTH. words_loaded increments in the same cycle as the pulse.
//   - The final word's write may coincide with the CSUM byte transfer; both must complete.
//  Boundary rules:
//   - start while in HDR0..CSUM is ignored.
//   - in_valid while in_ready = 0 is ignored and no byte is consumed.
//   - A gap in in_valid mid-word keeps the partial word and byte_idx.
//   - reset mid-load aborts immediately to the reset values. Memory words already written are
//     not cleared.
//   - ERROR leaves partially written memory in place; core_reset stays 1.
//  Width rule: the count is 16-bit unsigned and is compared against DEPTH without truncation.
// TESTING
//  1. reset -> core_reset=1, in_ready=0, done=0, error=0, mem_we=0; then start, frame N=1,
//     bytes 13 00 00 00, CSUM=13 -> one mem_we with addr 0, data 0x00000013; done=1; core_reset
//     falls the cycle after DONE.
//  2. N=3, words 0x00500093, 0x00A00113, 0x002081B3, correct CSUM -> exactly 3 mem_we pulses at
//     addr 0, 1, 2 with the matching data; words_loaded=3; done=1.
//  3. N=2 with a wrong CSUM byte (csum^0x01) -> both words written, error=1, done=0,
//     core_reset stays 1, in_ready=0.
//  4. Header N=0, and separately N=65 with DEPTH=64 -> ERROR immediately after CNT_HI, no
//     mem_we, in_ready=0.
//  5. in_valid toggled randomly (about 50%) during an N=4 frame, plus a start pulse mid-frame ->
//     identical writes to a gap-free frame; the mid-frame start has no effect.
//  6. reset asserted after 6 payload bytes, then start and a full N=2 frame -> outputs return to
//     reset values at once; the new load writes addr 0 and 1 and reaches done=1.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: framed byte stream into word-indexed instruction memory
module imem_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, CSUM, DONE, ERROR} state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state, next_state;
  logic [15:0] cnt;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [23:0] word_lo;
  logic        xfer;
  logic        last_byte;
  logic        restart;
  logic [15:0] hdr_cnt;

  assign xfer      = in_valid & in_ready;
  assign hdr_cnt   = {in_data, cnt[7:0]};
  // words_loaded already counts every completed word, so the frame ends on byte 3 of word cnt-1
  assign last_byte = (byte_idx == 2'd3) && ((words_loaded + 16'd1) == cnt);
  assign restart   = start && (state == IDLE || state == DONE || state == ERROR);

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE:  if (start) next_state = HDR0;
      HDR0: begin
        in_ready = 1'b1;
        if (xfer) next_state = HDR1;
      end
      HDR1: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (hdr_cnt == 16'd0 || {1'b0, hdr_cnt} > DEPTH_W) next_state = ERROR;
          else next_state = LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (xfer && last_byte) next_state = CSUM;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (xfer) next_state = (in_data == csum) ? DONE : ERROR;
      end
      DONE:    if (start) next_state = HDR0;
      ERROR:   if (start) next_state = HDR0;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      word_lo      <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state  <= next_state;
      mem_we <= 1'b0;
      done   <= (next_state == DONE);
      error  <= (next_state == ERROR);
      // core leaves reset one cycle after DONE is entered, and re-enters it on any restart
      core_reset <= !(next_state == DONE && state == DONE);
      if (mem_we) mem_addr <= mem_addr + 1'b1;
      if (xfer && state == HDR0) cnt[7:0]  <= in_data;
      if (xfer && state == HDR1) cnt[15:8] <= in_data;
      if (xfer && state == LOAD) begin
        csum     <= csum ^ in_data;
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0: word_lo[7:0]   <= in_data;
          2'd1: word_lo[15:8]  <= in_data;
          2'd2: word_lo[23:16] <= in_data;
          default: begin
            mem_wdata    <= {in_data, word_lo};
            mem_we       <= 1'b1;
            words_loaded <= words_loaded + 16'd1;
          end
        endcase
      end
      if (restart) begin
        csum         <= '0;
        byte_idx     <= '0;
        words_loaded <= '0;
        mem_addr     <= '0;
      end
    end
  end

endmodule
